// File: rtl/seg_scan_pkg.sv
// Shared constants for the 7-segment scan controller: blank pattern,
// segment bit positions and the active-low hex glyph table.
package seg_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Bit positions of each segment inside seg[6:0] = {a,b,c,d,e,f,g}
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Pure combinational hex nibble to active-low segment decoder.
module hex_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the glyph for this nibble
  always_comb begin
    seg = SEG_HEX[nibble];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed, tear-free hex display scanner for DIGITS digits.
// Define SEG_SCAN_LZB_EN to blank leading zero digits (last digit always shown).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 32768
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] pending_r;
  logic [4*DIGITS-1:0] shown_r;
  logic [6:0]          seg_r;
  logic [DIGITS-1:0]   an_r;
  logic                frame_tick_r;

  logic                slot_tick_s;
  logic                frame_end_s;
  logic [3:0]          nibble_s;
  logic [6:0]          dec_seg_s;
  logic                visible_s;
  logic [DIGITS-1:0]   an_sel_s;
  logic [DIGITS-1:0]   blank_lead_s;

  assign slot_tick_s = (cnt_r == CNT_LAST);
  assign frame_end_s = slot_tick_s && (idx_r == IDX_LAST);

  // Prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else if (slot_tick_s) begin
      cnt_r <= '0;
      idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Pending capture; shown only moves at the frame boundary so a frame never tears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r    <= '0;
      shown_r      <= '0;
      frame_tick_r <= 1'b0;
    end else begin
      if (load) begin
        pending_r <= value;
      end
      if (frame_end_s) begin
        shown_r <= load ? value : pending_r;
      end
      frame_tick_r <= frame_end_s;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // Leading-zero mask: digit i blanked while it and all more-significant digits are 0
  always_comb begin
    logic zero_run;
    zero_run     = 1'b1;
    blank_lead_s = '0;
    for (int i = 0; i < DIGITS - 1; i++) begin
      zero_run        = zero_run && (shown_r[4*(DIGITS-1-i) +: 4] == 4'h0);
      blank_lead_s[i] = zero_run;
    end
  end
`else
  assign blank_lead_s = '0;
`endif

  // Select the nibble, anode and visibility for the current index
  always_comb begin
    nibble_s  = 4'h0;
    visible_s = 1'b0;
    an_sel_s  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        nibble_s    = shown_r[4*(DIGITS-1-i) +: 4];
        visible_s   = digit_en[i] && !blank_lead_s[i];
        an_sel_s[i] = 1'b0;
      end else begin
        an_sel_s[i] = 1'b1;
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_s),
    .seg    (dec_seg_s)
  );

  // Registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= SEG_BLANK;
      an_r  <= '1;
    end else begin
      seg_r <= visible_s ? dec_seg_s : SEG_BLANK;
      an_r  <= visible_s ? an_sel_s  : '1;
    end
  end

  assign seg        = seg_r;
  assign an         = an_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl: two instances (PRESCALE 4 and 1)
// checked against a slot/frame arithmetic model of the display.
module tb_seg_scan_ctrl;

  localparam int D = 4;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;
  logic        ft_a, ft_b;

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model state per instance: edges since reset release, pending, shown
  int          edges [2];
  logic [15:0] pend  [2];
  logic [15:0] shown [2];
  int          pre   [2] = '{4, 1};

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(D), .PRESCALE(4)) dut_a (
    .clk(clk), .rst(rst), .value(value), .load(load), .digit_en(digit_en),
    .seg(seg_a), .an(an_a), .frame_tick(ft_a)
  );

  seg_scan_ctrl #(.DIGITS(D), .PRESCALE(1)) dut_b (
    .clk(clk), .rst(rst), .value(value), .load(load), .digit_en(digit_en),
    .seg(seg_b), .an(an_b), .frame_tick(ft_b)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      edges[m] = 0;
      pend[m]  = 16'h0;
      shown[m] = 16'h0;
    end
  endtask

  // One clock edge: predict both instances from current inputs, then compare
  task automatic step();
    logic [6:0] es [2];
    logic [3:0] ea [2];
    logic       ef [2];
    for (int m = 0; m < 2; m++) begin
      int  k, idx;
      bit  vis;
      logic [15:0] upper;
      k     = edges[m] + 1;
      idx   = ((k - 1) / pre[m]) % D;
      upper = shown[m] >> (4 * (D - 1 - idx));
      vis   = digit_en[idx] && !(LZB && idx < D - 1 && upper == 16'h0);
      ea[m] = vis ? ~(4'b0001 << idx) : 4'hF;
      es[m] = vis ? glyph[upper[3:0]] : 7'h7F;
      ef[m] = ((k % (pre[m] * D)) == 0);
      if (ef[m]) shown[m] = load ? value : pend[m];
      if (load) pend[m] = value;
      edges[m] = k;
    end
    @(posedge clk);
    #1;
    check_value("seg_p4", {25'h0, seg_a}, {25'h0, es[0]});
    check_value("an_p4",  {28'h0, an_a},  {28'h0, ea[0]});
    check_value("tick_p4", {31'h0, ft_a}, {31'h0, ef[0]});
    check_value("seg_p1", {25'h0, seg_b}, {25'h0, es[1]});
    check_value("an_p1",  {28'h0, an_b},  {28'h0, ea[1]});
    check_value("tick_p1", {31'h0, ft_b}, {31'h0, ef[1]});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_word(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    step();
    load  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_value("rst_seg_p4", {25'h0, seg_a}, 32'h7F);
    check_value("rst_an_p4",  {28'h0, an_a},  32'hF);
    check_value("rst_tick_p4", {31'h0, ft_a}, 32'h0);
    check_value("rst_seg_p1", {25'h0, seg_b}, 32'h7F);
    check_value("rst_an_p1",  {28'h0, an_b},  32'hF);
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    digit_en = 4'hF;
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Zero display, then a full scan of 12AF
    run(20);
    load_word(16'h12AF);
    run(40);

    // Late loads inside a frame must wait for the boundary
    while ((edges[0] % 16) != 4) step();
    load_word(16'h0000);
    run(3);
    load_word(16'h8888);
    run(30);

    // Load coinciding with frame end bypasses pending
    while (((edges[0] + 1) % 16) != 0) step();
    load_word(16'hBEEF);
    run(36);

    // Enable mask
    digit_en = 4'b1010;
    run(20);
    digit_en = 4'hF;

    // Leading-zero patterns
    load_word(16'h0040);
    run(34);
    load_word(16'h0000);
    run(34);

    // Reset mid-slot
    while ((edges[0] % 4) != 2) step();
    rst = 1'b1;
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run(24);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom) >> $urandom_range(0, 16);
      if ($urandom_range(0, 19) == 0) digit_en = 4'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
